// File: rtl/systolic_array_3x3.sv
// Weight-stationary 3x3 systolic MAC array: weights shift in from the top,
// skewed activations flow left-to-right, partial sums flow downward.
module systolic_array_3x3 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A_in_1,
   input  logic [WIDTH-1:0] A_in_2,
   input  logic [WIDTH-1:0] A_in_3,
   input  logic [WIDTH-1:0] B_in_1,
   input  logic [WIDTH-1:0] B_in_2,
   input  logic [WIDTH-1:0] B_in_3,
   input  logic             P1_en,
   output logic [WIDTH-1:0] C_out
);

   logic [WIDTH-1:0] a_row [3];
   logic [WIDTH-1:0] b_col [3];

   logic [WIDTH-1:0] w_reg   [3][3];
   logic [WIDTH-1:0] a_reg   [3][3];
   logic [WIDTH-1:0] p_reg   [3][3];

   logic [WIDTH-1:0] w_next  [3][3];
   logic [WIDTH-1:0] a_next  [3][3];
   logic [WIDTH-1:0] psum_in [3][3];
   logic [WIDTH-1:0] prod    [3][3];
   logic [WIDTH-1:0] p_next  [3][3];

   assign a_row[0] = A_in_1;
   assign a_row[1] = A_in_2;
   assign a_row[2] = A_in_3;
   assign b_col[0] = B_in_1;
   assign b_col[1] = B_in_2;
   assign b_col[2] = B_in_3;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         for (gj = 0; gj < 3; gj++) begin : g_col
            if (gi == 0) begin : g_top
               assign w_next[gi][gj]  = b_col[gj];
               assign psum_in[gi][gj] = '0;
            end else begin : g_inner
               assign w_next[gi][gj]  = w_reg[gi-1][gj];
               assign psum_in[gi][gj] = p_reg[gi-1][gj];
            end

            if (gj == 0) begin : g_left
               assign a_next[gi][gj] = a_row[gi];
            end else begin : g_mid
               assign a_next[gi][gj] = a_reg[gi][gj-1];
            end

            // Product truncated to WIDTH bits; the accumulate wraps modulo 2^WIDTH.
            assign prod[gi][gj]   = a_next[gi][gj] * w_reg[gi][gj];
            assign p_next[gi][gj] = psum_in[gi][gj] + prod[gi][gj];
         end
      end
   endgenerate

   // Each PE multiplies with its pre-edge weight even when a load shifts on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               w_reg[r][c] <= '0;
               a_reg[r][c] <= '0;
               p_reg[r][c] <= '0;
            end
         end
      end else begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               a_reg[r][c] <= a_next[r][c];
               p_reg[r][c] <= p_next[r][c];
               if (P1_en) begin
                  w_reg[r][c] <= w_next[r][c];
               end
            end
         end
      end
   end

   assign C_out = p_reg[2][0] + p_reg[2][1] + p_reg[2][2];

endmodule

// File: tb/tb_systolic_array_3x3.sv
// Directed bench for systolic_array_3x3: weight loads, skewed vectors,
// wrap-around, weight hold, over-load shifting and asynchronous reset.
module tb_systolic_array_3x3;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] A_in_1, A_in_2, A_in_3;
   logic [WIDTH-1:0] B_in_1, B_in_2, B_in_3;
   logic             P1_en;
   logic [WIDTH-1:0] C_out;

   int total;
   int bad;

   systolic_array_3x3 #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .A_in_1 (A_in_1),
      .A_in_2 (A_in_2),
      .A_in_3 (A_in_3),
      .B_in_1 (B_in_1),
      .B_in_2 (B_in_2),
      .B_in_3 (B_in_3),
      .P1_en  (P1_en),
      .C_out  (C_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] exp);
      total++;
      assert (C_out === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, C_out, exp);
      end
      $display("check %-22s C_out=%0d expected=%0d", tag, C_out, exp);
   endtask

   task automatic load_row(input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b2,
                           input logic [WIDTH-1:0] b3);
      P1_en  = 1'b1;
      B_in_1 = b1;
      B_in_2 = b2;
      B_in_3 = b3;
      tick();
      P1_en  = 1'b0;
      B_in_1 = '0;
      B_in_2 = '0;
      B_in_3 = '0;
   endtask

   // Skewed vector; e0..e2 are the column results following the edge that samples A_in_3.
   task automatic run_vec(input string tag,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a2,
                          input logic [WIDTH-1:0] a3,
                          input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                          input logic [WIDTH-1:0] e2);
      A_in_1 = a1;
      tick();
      A_in_1 = '0;
      A_in_2 = a2;
      tick();
      A_in_2 = '0;
      A_in_3 = a3;
      tick();
      check($sformatf("%s_col0", tag), e0);
      A_in_3 = '0;
      tick();
      check($sformatf("%s_col1", tag), e1);
      tick();
      check($sformatf("%s_col2", tag), e2);
      tick();
      check($sformatf("%s_idle", tag), '0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      P1_en  = 1'b0;
      A_in_1 = '0; A_in_2 = '0; A_in_3 = '0;
      B_in_1 = '0; B_in_2 = '0; B_in_3 = '0;

      repeat (2) tick();
      check("reset_state", '0);
      rst = 1'b1;
      tick();
      check("after_release", '0);

      // Rows become row0=(7,8,9), row1=(4,5,6), row2=(1,2,3).
      load_row(8'd1, 8'd2, 8'd3);
      load_row(8'd4, 8'd5, 8'd6);
      load_row(8'd7, 8'd8, 8'd9);
      run_vec("basic", 8'd1, 8'd2, 8'd3, 8'd18, 8'd24, 8'd30);

      // Asynchronous reset while a nonzero result is on the output.
      A_in_1 = 8'd1; tick();
      A_in_1 = '0; A_in_2 = 8'd2; tick();
      A_in_2 = '0; A_in_3 = 8'd3; tick();
      check("async_pre", 8'd18);
      #2 rst = 1'b0;
      #1 check("async_now", '0);
      A_in_3 = '0;
      tick();
      check("async_held", '0);
      rst = 1'b1;
      tick();
      check("async_released", '0);
      run_vec("cleared", 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0);

      load_row(8'd0, 8'd0, 8'd1);
      load_row(8'd0, 8'd1, 8'd0);
      load_row(8'd1, 8'd0, 8'd0);
      run_vec("identity", 8'd5, 8'd6, 8'd7, 8'd5, 8'd6, 8'd7);

      load_row(8'd16, 8'd16, 8'd16);
      load_row(8'd16, 8'd16, 8'd16);
      load_row(8'd16, 8'd16, 8'd16);
      run_vec("wrap_16", 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      run_vec("wrap_15_1", 8'd15, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
      run_vec("nowrap_111", 8'd1, 8'd1, 8'd1, 8'd48, 8'd48, 8'd48);

      load_row(8'd1, 8'd2, 8'd3);
      load_row(8'd4, 8'd5, 8'd6);
      load_row(8'd7, 8'd8, 8'd9);
      repeat (10) tick();
      check("hold_idle", '0);
      run_vec("hold", 8'd1, 8'd2, 8'd3, 8'd18, 8'd24, 8'd30);

      // Four loads: the first row falls off the bottom.
      load_row(8'd9, 8'd9, 8'd9);
      load_row(8'd1, 8'd2, 8'd3);
      load_row(8'd4, 8'd5, 8'd6);
      load_row(8'd7, 8'd8, 8'd9);
      run_vec("overload", 8'd1, 8'd2, 8'd3, 8'd18, 8'd24, 8'd30);

      // Reset one cycle after A_in_1 is applied.
      A_in_1 = 8'd1;
      tick();
      rst = 1'b0;
      #1 check("mid_reset", '0);
      A_in_1 = '0; A_in_2 = 8'd2;
      tick();
      rst = 1'b1;
      A_in_2 = '0; A_in_3 = 8'd3;
      tick();
      check("mid_col0", '0);
      A_in_3 = '0;
      tick();
      check("mid_col1", '0);
      tick();
      check("mid_col2", '0);
      run_vec("mid_reapply", 8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
